// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   alu_op_t    - 3-bit opcode (ADD, SUB, AND, OR, XOR, SHL, SHR, MUL)
//   mul_state_t - state encoding of the shift-add multiplier
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: W-iteration shift-add unsigned multiplier.
//   Clk, Reset_n  clock, async active-low reset
//   start         begin a multiply (accepted only when idle)
//   a, b          multiplicand, multiplier
//   busy          multiply in progress
//   done          high during the final iteration cycle
//   prod          2W-bit product, valid while done is high
//
// state  | meaning
// S_IDLE | waiting for start
// S_MUL  | one add/shift iteration per cycle, counter runs W down to 0
module alu_shift_add_mul
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int SW = $clog2(W);
    localparam int CW = SW + 1;

    mul_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_nxt;
    logic           last;

    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Terminal count: this iteration takes the counter to zero.
    assign last = (state_q == S_MUL) && (cnt_q == CW'(1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_MUL;
            S_MUL:   if (last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                cnt_q    <= CW'(W);
                mcand_q  <= {{W{1'b0}}, a};
                mplier_q <= b;
                acc_q    <= '0;
            end
        end else begin
            cnt_q    <= cnt_q - CW'(1);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_nxt;
        end
    end

    assign busy = (state_q == S_MUL);
    assign done = last;
    // The parent registers the product on the same edge that finishes the
    // last iteration, so expose the post-add value rather than acc_q.
    assign prod = acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with Start/Busy/Done handshake.
//   Clk, Reset_n      clock, async active-low reset
//   Start, OP         request and opcode (sampled only while Busy=0)
//   InputA, InputB    operands; shifts use InputB[SW-1:0]
//   Out               registered result
//   Zero, LT, Carry   flags, updated together with Out
//   Busy              multiply in progress
//   Done              one-cycle pulse when Out/flags were updated
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [OP_W-1:0] OP,
    input  logic [W-1:0]    InputA,
    input  logic [W-1:0]    InputB,
    output logic [W-1:0]    Out,
    output logic            Zero,
    output logic            LT,
    output logic            Carry,
    output logic            Busy,
    output logic            Done
);

    localparam int SW = $clog2(W);

    alu_op_t        op;
    logic [SW-1:0]  shamt;
    logic [W-1:0]   res;
    logic           res_c;
    logic           start_ok;
    logic           alu_start;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [2*W-1:0] mul_prod;
    logic           lt_cap_q;

    assign op    = alu_op_t'(OP);
    assign shamt = InputB[SW-1:0];

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (op)
            OP_ADD: {res_c, res} = {1'b0, InputA} + {1'b0, InputB};
            // Bit W of the widened difference is the borrow.
            OP_SUB: {res_c, res} = {1'b0, InputA} - {1'b0, InputB};
            OP_AND: res = InputA & InputB;
            OP_OR:  res = InputA | InputB;
            OP_XOR: res = InputA ^ InputB;
            // Widening by one bit catches the last bit shifted out; a zero
            // shift leaves the catch bit at 0.
            OP_SHL: {res_c, res} = {1'b0, InputA} << shamt;
            OP_SHR: {res, res_c} = {InputA, 1'b0} >> shamt;
            default: begin
                res   = '0;
                res_c = 1'b0;
            end
        endcase
    end

    assign start_ok  = Start && !mul_busy;
    assign mul_start = start_ok && (op == OP_MUL);
    assign alu_start = start_ok && (op != OP_MUL);

    alu_shift_add_mul #(.W(W)) u_mul (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (mul_start),
        .a       (InputA),
        .b       (InputB),
        .busy    (mul_busy),
        .done    (mul_done),
        .prod    (mul_prod)
    );

    // LT reflects the operands at Start but is only published with Done.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)       lt_cap_q <= 1'b0;
        else if (mul_start) lt_cap_q <= (InputA < InputB);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out   <= '0;
            Zero  <= 1'b0;
            LT    <= 1'b0;
            Carry <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (alu_start) begin
                Out   <= res;
                Zero  <= (res == '0);
                LT    <= (InputA < InputB);
                Carry <= res_c;
                Done  <= 1'b1;
            end else if (mul_done) begin
                Out   <= mul_prod[W-1:0];
                Zero  <= (mul_prod[W-1:0] == '0);
                LT    <= lt_cap_q;
                Carry <= |mul_prod[2*W-1:W];
                Done  <= 1'b1;
            end
        end
    end

    assign Busy = mul_busy;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 8;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic [2:0]   OP;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic [W-1:0] Out;
    logic         Zero;
    logic         LT;
    logic         Carry;
    logic         Busy;
    logic         Done;

    int errors = 0;
    int checks = 0;

    alu_seq #(.W(W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .OP      (OP),
        .InputA  (InputA),
        .InputB  (InputB),
        .Out     (Out),
        .Zero    (Zero),
        .LT      (LT),
        .Carry   (Carry),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on integers, modulo 256.
    task automatic ref_op(input int op, input int a, input int b,
                          output int res, output int carry);
        int n;
        int s;
        n = b % W;
        case (op)
            0: begin s = a + b; res = s % 256; carry = (s > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; carry = (a < b) ? 1 : 0; end
            2: begin res = a & b; carry = 0; end
            3: begin res = a | b; carry = 0; end
            4: begin res = a ^ b; carry = 0; end
            5: begin
                s = a * (1 << n);
                res = s % 256;
                carry = (n == 0) ? 0 : ((s / 256) % 2);
            end
            6: begin
                res = a / (1 << n);
                carry = (n == 0) ? 0 : ((a / (1 << (n - 1))) % 2);
            end
            default: begin
                s = a * b;
                res = s % 256;
                carry = (s > 255) ? 1 : 0;
            end
        endcase
    endtask

    // Issue one operation at a negedge and follow it to Done. inject >= 0
    // pulses an ADD Start at that many cycles into a MUL (must be ignored).
    task automatic run_op(input string tag, input int op, input int a, input int b,
                          input int inject);
        int exp_res, exp_c, exp_lt, lat, busy_cnt;
        ref_op(op, a, b, exp_res, exp_c);
        exp_lt = (a < b) ? 1 : 0;
        Start  = 1'b1;
        OP     = 3'(op);
        InputA = 8'(a);
        InputB = 8'(b);
        @(negedge Clk);
        Start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        if (op == 7) begin
            while (Done !== 1'b1 && lat < W + 5) begin
                if (Busy === 1'b1) busy_cnt++;
                if (lat == inject) begin
                    Start  = 1'b1;
                    OP     = 3'd0;
                    InputA = 8'd3;
                    InputB = 8'd4;
                end else begin
                    Start = 1'b0;
                end
                @(negedge Clk);
                lat++;
            end
            Start = 1'b0;
            check({tag, ".latency"}, lat, W);
            check({tag, ".busy_cycles"}, busy_cnt, W);
            check({tag, ".busy_at_done"}, Busy, 0);
        end
        check({tag, ".done"}, Done, 1);
        check({tag, ".out"}, Out, exp_res);
        check({tag, ".zero"}, Zero, (exp_res == 0) ? 1 : 0);
        check({tag, ".carry"}, Carry, exp_c);
        check({tag, ".lt"}, LT, exp_lt);
        @(negedge Clk);
        check({tag, ".done_drop"}, Done, 0);
        check({tag, ".out_hold"}, Out, exp_res);
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        OP      = 3'd0;
        InputA  = '0;
        InputB  = '0;
        repeat (2) @(negedge Clk);
        check("reset.outputs", {Out, Zero, LT, Carry, Busy, Done}, 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        run_op("add_ff_01", 0, 8'hFF, 8'h01, -1);
        run_op("sub_02_01", 1, 8'h02, 8'h01, -1);
        run_op("sub_01_02", 1, 8'h01, 8'h02, -1);
        run_op("mul_0d_0b", 7, 8'h0D, 8'h0B, -1);
        run_op("mul_10_10", 7, 8'h10, 8'h10, -1);
        run_op("shl_81_1",  5, 8'h81, 8'h01, -1);
        run_op("shr_81_0",  6, 8'h81, 8'h00, -1);
        run_op("shr_81_1",  6, 8'h81, 8'h01, -1);
        run_op("shl_01_7",  5, 8'h01, 8'h07, -1);
        run_op("xor_aa_aa", 4, 8'hAA, 8'hAA, -1);
        run_op("mul_busy_start", 7, 8'h0D, 8'h0B, 3);

        // Back-to-back non-MUL: Done stays high on consecutive cycles.
        Start = 1'b1; OP = 3'd3; InputA = 8'h0F; InputB = 8'hF0;
        @(negedge Clk);
        check("b2b.first_done", Done, 1);
        check("b2b.first_out", Out, 8'hFF);
        OP = 3'd2; InputA = 8'h3C; InputB = 8'h0F;
        @(negedge Clk);
        Start = 1'b0;
        check("b2b.second_done", Done, 1);
        check("b2b.second_out", Out, 8'h0C);
        @(negedge Clk);

        // Abort a multiply mid-flight.
        Start = 1'b1; OP = 3'd7; InputA = 8'hFF; InputB = 8'hFF;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1 check("abort.outputs", {Out, Zero, LT, Carry, Busy, Done}, 0);
        repeat (2) begin
            @(negedge Clk);
            check("abort.no_done", Done, 0);
        end
        Reset_n = 1'b1;
        repeat (W + 2) begin
            @(negedge Clk);
            check("abort.stays_idle", {Busy, Done}, 0);
        end
        run_op("add_3_4", 0, 3, 4, -1);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational ALU, and the datapath ALU of the processor core. It adds a Start/Busy/Done handshake, eight operations including barrel shifts and a multi-cycle shift-add multiply, and a Carry flag. Outputs are registered and held until the next completed operation.

## Interface
- W, default 8: datapath width; power of two, ≥4.
- SW, default $clog2(W): shift-amount width; derived, not overridden.

- Clk  in  1  rising-edge clock.
- Reset_n  in  1  reset, asynchronous, active-low.
- Start  in  1  operation request; sampled only when Busy=0.
- OP  in  3  opcode, encoded in alu_pkg:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SHL, 110 SHR, 111 MUL
- InputA  in  W  operand A.
- InputB  in  W  operand B; for shifts, only InputB[SW-1:0] is used.
- Out  out  W  registered result.
- Zero  out  1  Out == 0.
- LT  out  1  InputA < InputB, unsigned, using operands captured at Start.
- Carry  out  1  operation-specific carry/overflow.
- Busy  out  1  MUL in progress.
- Done  out  1  one-cycle pulse: Out and flags updated this cycle.

## Operation
- FSM states: IDLE, MUL.
- IDLE, Start=1, OP≠MUL:
  - Result, Zero, LT and Carry are registered at the sampling edge.
  - Done=1 for the following cycle.
  - FSM stays in IDLE, so back-to-back Starts are accepted every cycle.
- IDLE, Start=1, OP=MUL:
  - Capture A, B and LT; clear the 2W-bit accumulator; set the iteration counter to W; go to MUL; Busy=1.
- MUL, each cycle:
  - If multiplier LSB = 1, add the shifted multiplicand to the accumulator.
  - Shift the multiplier right and the multiplicand left; decrement the counter.
- MUL, on the edge where the counter reaches 0:
  - Out = acc[W-1:0]; Carry = |acc[2W-1:W]; Zero from Out.
  - Done=1, Busy=0, return to IDLE.
- Carry rules:
  - ADD: carry out of bit W-1.
  - SUB: borrow (A<B).
  - SHL: last bit shifted out, i.e. A[W-n].
  - SHR (logical): last bit shifted out, i.e. A[n-1].
  - Shift by n=0: Carry=0.
  - AND/OR/XOR: Carry=0.
- All arithmetic is modulo 2^W and unsigned.
- Start while Busy=1 is ignored entirely: no capture, no Done, no effect on the MUL in progress.
- Out and flags hold their last values between Done pulses.
- Reset_n low, at any time including mid-MUL:
  - Immediately Out=0, Zero=0, LT=0, Carry=0, Busy=0, Done=0; FSM to IDLE; counter and accumulator cleared.
  - The aborted operation produces no Done.

## Timing
- Non-MUL: Start sampled at edge k → Out, flags and Done valid after edge k. Latency 1 cycle.
- MUL: Start at edge k → Busy high after k → iterations on edges k+1..k+W.
  - Done high and Busy low after edge k+W.
  - Busy is high for exactly W cycles; latency W cycles.
- Done is never high for two consecutive cycles of the same operation.
- Done may be high in consecutive cycles for back-to-back non-MUL operations.
- Reset values: every output 0. Zero resets to 0 even though Out=0; it is valid only from the first Done.

## Structure
- alu_pkg:
  - opcode enum alu_op_t (ADD..MUL, 3 bits).
  - localparam OP_W=3.
- Sub-module alu_shift_add_mul:
  - MUL FSM, counter, accumulator.
  - Ports Clk, Reset_n, start, a, b → busy, done, prod[2W-1:0].
- Top level: combinational op mux, flag logic, output registers, Start gating on Busy.

## Test plan (W=8)
- ADD 0xFF+0x01 → Out=0x00, Zero=1, Carry=1, LT=0; Done one cycle after Start.
- SUB 0x02-0x01 → 0x01, Carry=0, LT=0; then SUB 0x01-0x02 → 0xFF, Carry=1, LT=1, Zero=0.
- MUL 0x0D*0x0B → Out=0x8F, Carry=0; Busy high 8 cycles; Done exactly 8 cycles after Start. MUL 0x10*0x10 → Out=0x00, Zero=1, Carry=1.
- SHL 0x81 by 1 → 0x02, Carry=1; SHR 0x81 by 0 → 0x81, Carry=0; XOR 0xAA^0xAA → 0x00, Zero=1, Carry=0.
- Start ADD pulsed while a MUL is Busy → ignored; the MUL result is unchanged and exactly one Done is seen.
- Reset_n low at MUL cycle 4 → all outputs 0 immediately, no Done; after release, ADD 3+4 → Out=0x07.
